// File: rtl/serial_port_pkg.sv
// Shared types and constants for the 0xBF00 board UART responder:
// FSM encodings, frame width, bus release value and mid-bit timing.
package serial_port_pkg;

   localparam int DATA_BITS = 8;
   localparam logic [DATA_BITS-1:0] BUS_IDLE = 8'hzz;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   // Counter value at which a start edge is re-checked, half a bit in.
   function automatic int mid_bit_count(input int clks_per_bit);
      return (clks_per_bit / 2) - 1;
   endfunction

endpackage

// File: rtl/serial_rx_frame.sv
// 8N1 receiver: rxd synchronizer, start-glitch rejection and LSB-first
// deserializer. Emits a byte with one-cycle byte_valid / frame_bad strobes.
module serial_rx_frame
   import serial_port_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rxd_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 byte_valid_o,
   output logic                 frame_bad_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID_CNT  = CW'(mid_bit_count(CLKS_PER_BIT));
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   rx_state_e            state_q;
   logic                 rx_meta_q;
   logic                 rxs_q;
   logic [CW-1:0]        cnt_q;
   logic [BW-1:0]        bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 bad_q;

   // Synchronizer plus receive FSM; after the start check every sample is a bit centre.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         bad_q     <= 1'b0;
      end else begin
         rx_meta_q <= rxd_i;
         rxs_q     <= rx_meta_q;
         valid_q   <= 1'b0;
         bad_q     <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               if (!rxs_q) begin
                  state_q <= RX_START;
                  cnt_q   <= '0;
               end
            end
            RX_START: begin
               if (cnt_q == MID_CNT) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  state_q <= rxs_q ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_q   <= '0;
                  shift_q <= {rxs_q, shift_q[DATA_BITS-1:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == LAST_BIT) begin
                     state_q <= RX_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_q   <= '0;
                  state_q <= RX_IDLE;
                  if (rxs_q) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                  end else begin
                     bad_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   assign data_o       = data_q;
   assign byte_valid_o = valid_q;
   assign frame_bad_o  = bad_q;

endmodule

// File: rtl/serial_port_responder.sv
// Device-side model of the board UART at 0xBF00: strobe edge detection,
// THR/TSR transmitter, RBR with ready/error flags, and the shared data bus.
module serial_port_responder
   import serial_port_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 rdn,
   input  logic                 wrn,
   inout  wire  [DATA_BITS-1:0] bus_data,
   output logic                 data_ready,
   output logic                 tbre,
   output logic                 tsre,
   output logic                 txd,
   input  logic                 rxd,
   output logic                 frame_err,
   output logic                 rx_overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   logic                 rdn_q, wrn_q;
   logic                 wr_event, rd_done;
   tx_state_e            tx_state_q;
   logic [CW-1:0]        tx_cnt_q;
   logic [BW-1:0]        tx_bit_q;
   logic [DATA_BITS-1:0] thr_q, tsr_q, rbr_q;
   logic                 tbre_q, tsre_q, txd_q;
   logic                 data_ready_q, frame_err_q, rx_overrun_q;
   logic [DATA_BITS-1:0] rx_byte;
   logic                 rx_valid, rx_bad;

   assign wr_event = wrn_q & ~wrn;
   assign rd_done  = ~rdn_q & rdn;
   assign bus_data = rdn ? BUS_IDLE : rbr_q;

   serial_rx_frame #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk_i        (CLK),
      .rst_ni       (RST),
      .rxd_i        (rxd),
      .data_o       (rx_byte),
      .byte_valid_o (rx_valid),
      .frame_bad_o  (rx_bad)
   );

   // Transmit FSM and THR write; tbre is only raised from 0 and only lowered from 1, so they never collide.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         thr_q      <= '0;
         tsr_q      <= '0;
         tbre_q     <= 1'b1;
         tsre_q     <= 1'b1;
         txd_q      <= 1'b1;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               if (!tbre_q) begin
                  tsr_q      <= thr_q;
                  tbre_q     <= 1'b1;
                  tsre_q     <= 1'b0;
                  txd_q      <= 1'b0;
                  tx_cnt_q   <= '0;
                  tx_state_q <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt_q == LAST_CNT) begin
                  tx_cnt_q   <= '0;
                  tx_bit_q   <= '0;
                  txd_q      <= tsr_q[0];
                  tx_state_q <= TX_DATA;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_cnt_q == LAST_CNT) begin
                  tx_cnt_q <= '0;
                  if (tx_bit_q == LAST_BIT) begin
                     txd_q      <= 1'b1;
                     tx_state_q <= TX_STOP;
                  end else begin
                     tsr_q    <= {1'b0, tsr_q[DATA_BITS-1:1]};
                     txd_q    <= tsr_q[1];
                     tx_bit_q <= tx_bit_q + 1'b1;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            TX_STOP: begin
               if (tx_cnt_q == LAST_CNT) begin
                  tx_cnt_q <= '0;
                  if (!tbre_q) begin
                     tsr_q      <= thr_q;
                     tbre_q     <= 1'b1;
                     txd_q      <= 1'b0;
                     tx_state_q <= TX_START;
                  end else begin
                     tsre_q     <= 1'b1;
                     tx_state_q <= TX_IDLE;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            default: tx_state_q <= TX_IDLE;
         endcase
         if (wr_event && tbre_q) begin
            thr_q  <= bus_data;
            tbre_q <= 1'b0;
         end
      end
   end

   // Strobe registers, RBR and receive flags; a byte landing with a read-done is not an overrun.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         rdn_q        <= 1'b1;
         wrn_q        <= 1'b1;
         rbr_q        <= '0;
         data_ready_q <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         rdn_q <= rdn;
         wrn_q <= wrn;
         if (rx_valid) begin
            rbr_q        <= rx_byte;
            data_ready_q <= 1'b1;
            if (data_ready_q && !rd_done) begin
               rx_overrun_q <= 1'b1;
            end
         end else if (rd_done) begin
            data_ready_q <= 1'b0;
         end
         if (rx_bad) begin
            frame_err_q <= 1'b1;
         end
      end
   end

   assign data_ready = data_ready_q;
   assign tbre       = tbre_q;
   assign tsre       = tsre_q;
   assign txd        = txd_q;
   assign frame_err  = frame_err_q;
   assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_serial_port_responder.sv
// Directed bench for serial_port_responder: a TX bit queue and an RX byte
// queue hold expected results, compared as the DUT produces them.
module tb_serial_port_responder;

   localparam int CPB = 16;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   logic rdn = 1'b1;
   logic wrn = 1'b1;
   logic rxd = 1'b1;
   wire  [7:0] bus_data;
   logic data_ready, tbre, tsre, txd, frame_err, rx_overrun;

   logic       drv_en  = 1'b0;
   logic [7:0] drv_val = 8'h00;
   assign bus_data = drv_en ? drv_val : 8'hzz;

   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   bit   mon_en      = 1'b0;
   bit   exp_ovr     = 1'b0;
   bit   exp_ferr    = 1'b0;
   bit   tx_q[$];
   logic [7:0] rx_q[$];

   serial_port_responder #(.CLKS_PER_BIT(CPB)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .rdn        (rdn),
      .wrn        (wrn),
      .bus_data   (bus_data),
      .data_ready (data_ready),
      .tbre       (tbre),
      .tsre       (tsre),
      .txd        (txd),
      .rxd        (rxd),
      .frame_err  (frame_err),
      .rx_overrun (rx_overrun)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_released();
      drv_val = 8'h00;
      drv_en  = 1'b1;
      #1;
      check("bus_released", {24'h0, bus_data}, 32'h0);
      drv_en  = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] v, input bit expect_tx);
      if (expect_tx) begin
         tx_q.push_back(1'b0);
         for (int i = 0; i < 8; i++) tx_q.push_back(v[i]);
         tx_q.push_back(1'b1);
      end
      @(negedge CLK);
      drv_val = v;
      drv_en  = 1'b1;
      wrn     = 1'b0;
      @(negedge CLK);
      wrn     = 1'b1;
      drv_en  = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] v, input bit stop, input int rd_at);
      logic [9:0] fr;
      fr = {stop, v, 1'b0};
      if (stop) begin
         if (rx_q.size() != 0) begin
            exp_ovr = 1'b1;
            rx_q.delete();
         end
         rx_q.push_back(v);
      end else begin
         exp_ferr = 1'b1;
      end
      for (int i = 0; i < 10 * CPB; i++) begin
         @(negedge CLK);
         rxd = fr[i / CPB];
         if (i == rd_at) rdn = 1'b1;
      end
      @(negedge CLK);
      rxd = 1'b1;
   endtask

   task automatic do_read(input string tag);
      logic [7:0] e;
      @(negedge CLK);
      rdn = 1'b0;
      #1;
      if (rx_q.size() == 0) begin
         check({tag, "_empty"}, 32'd1, 32'd0);
      end else begin
         e = rx_q.pop_front();
         check(tag, {24'h0, bus_data}, {24'h0, e});
      end
      @(negedge CLK);
      rdn = 1'b1;
      @(negedge CLK);
      check({tag, "_dr_clear"}, {31'h0, data_ready}, 32'd0);
      check_released();
   endtask

   task automatic wait_tsre(input int t0, input int exp_dt, input string tag);
      int dt;
      dt = -1;
      for (int k = 0; k < 1000; k++) begin
         @(negedge CLK);
         if (tsre) begin
            dt = cyc - t0;
            break;
         end
      end
      check(tag, dt, exp_dt);
   endtask

   // Serial line monitor: samples every bit centre of each frame against tx_q.
   initial begin : tx_monitor
      logic prev;
      prev = 1'b1;
      forever begin
         @(negedge CLK);
         if (mon_en && prev && !txd) begin
            for (int b = 0; b < 10; b++) begin
               if (b == 0) repeat (CPB / 2 - 1) @(negedge CLK);
               else        repeat (CPB) @(negedge CLK);
               if (tx_q.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
               else check($sformatf("tx_bit%0d", b), {31'h0, txd}, {31'h0, tx_q.pop_front()});
            end
         end
         prev = txd;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : stimulus
      int t0;
      // Reset state, bus released while held in reset
      repeat (3) @(negedge CLK);
      check("rst_txd", {31'h0, txd}, 32'd1);
      check("rst_tbre", {31'h0, tbre}, 32'd1);
      check("rst_tsre", {31'h0, tsre}, 32'd1);
      check("rst_dr", {31'h0, data_ready}, 32'd0);
      check("rst_ferr", {31'h0, frame_err}, 32'd0);
      check("rst_ovr", {31'h0, rx_overrun}, 32'd0);
      check_released();
      RST = 1'b1;
      @(negedge CLK);
      mon_en = 1'b1;

      // Single frame 0xA5
      do_write(8'hA5, 1'b1);
      check("a5_tbre_low", {31'h0, tbre}, 32'd0);
      @(negedge CLK);
      check("a5_tbre_back", {31'h0, tbre}, 32'd1);
      check("a5_tsre_busy", {31'h0, tsre}, 32'd0);
      check("a5_start_bit", {31'h0, txd}, 32'd0);
      t0 = cyc;
      wait_tsre(t0, 10 * CPB, "a5_frame_len");
      check("a5_txq_drained", tx_q.size(), 32'd0);

      // Back-to-back 0x01, 0x80; a third write while THR is full is dropped
      do_write(8'h01, 1'b1);
      @(negedge CLK);
      t0 = cyc;
      check("b2b_tbre_free", {31'h0, tbre}, 32'd1);
      do_write(8'h80, 1'b1);
      check("b2b_tbre_full", {31'h0, tbre}, 32'd0);
      do_write(8'hEE, 1'b0);
      check("drop_tbre_full", {31'h0, tbre}, 32'd0);
      wait_tsre(t0, 20 * CPB, "b2b_two_frames_len");
      check("b2b_txq_drained", tx_q.size(), 32'd0);

      // Receive 0x3C and read it back
      send_rx(8'h3C, 1'b1, -1);
      check("rx3c_dr", {31'h0, data_ready}, 32'd1);
      do_read("rd_3c");

      // Byte completing on the read-done edge keeps data_ready
      send_rx(8'h33, 1'b1, -1);
      @(negedge CLK);
      rdn = 1'b0;
      #1;
      check("rd_33", {24'h0, bus_data}, {24'h0, rx_q.pop_front()});
      send_rx(8'h44, 1'b1, 10 * CPB - 5);
      check("same_edge_dr", {31'h0, data_ready}, 32'd1);
      check("same_edge_ovr", {31'h0, rx_overrun}, {31'h0, exp_ovr});
      do_read("rd_44");

      // Start-bit glitch, then a frame with a bad stop bit
      @(negedge CLK);
      rxd = 1'b0;
      repeat (4) @(negedge CLK);
      rxd = 1'b1;
      repeat (40) @(negedge CLK);
      check("glitch_dr", {31'h0, data_ready}, 32'd0);
      check("glitch_ferr", {31'h0, frame_err}, {31'h0, exp_ferr});
      send_rx(8'h55, 1'b0, -1);
      repeat (40) @(negedge CLK);
      check("ferr_set", {31'h0, frame_err}, {31'h0, exp_ferr});
      check("ferr_dr", {31'h0, data_ready}, {31'h0, (rx_q.size() != 0)});

      // Overrun: 0x11 then 0x22 unread
      send_rx(8'h11, 1'b1, -1);
      send_rx(8'h22, 1'b1, -1);
      check("ovr_set", {31'h0, rx_overrun}, {31'h0, exp_ovr});
      check("ovr_dr", {31'h0, data_ready}, 32'd1);
      do_read("rd_22");

      // Reset in the middle of a 0xFF frame, then a clean frame
      mon_en = 1'b0;
      do_write(8'hFF, 1'b0);
      repeat (50) @(negedge CLK);
      RST = 1'b0;
      exp_ovr  = 1'b0;
      exp_ferr = 1'b0;
      rx_q.delete();
      @(negedge CLK);
      check("midrst_txd", {31'h0, txd}, 32'd1);
      check("midrst_tbre", {31'h0, tbre}, 32'd1);
      check("midrst_tsre", {31'h0, tsre}, 32'd1);
      check("midrst_ferr", {31'h0, frame_err}, {31'h0, exp_ferr});
      check("midrst_ovr", {31'h0, rx_overrun}, {31'h0, exp_ovr});
      RST = 1'b1;
      @(negedge CLK);
      mon_en = 1'b1;
      do_write(8'h96, 1'b1);
      @(negedge CLK);
      check("post_rst_start", {31'h0, txd}, 32'd0);
      t0 = cyc;
      wait_tsre(t0, 10 * CPB, "post_rst_frame_len");
      repeat (4) @(negedge CLK);
      check("end_txq_drained", tx_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
